// File: rtl/mem_stage_rv.sv
// Memory-access stage: issues RISC-V loads/stores over a req/ack data-memory port,
// formats load data and stalls the pipeline while an access is outstanding.
module mem_stage_rv #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic [31:0]       ALUresult,
    input  logic [31:0]       writeData,
    input  logic              registerWrite,
    input  logic              memoryToRegister,
    input  logic [4:0]        writeRegister,
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [ADDR_W-1:0] dmemAddr,
    output logic [31:0]       dmemWdata,
    output logic [3:0]        dmemWstrb,
    input  logic [31:0]       dmemRdata,
    input  logic              dmemAck,
    output logic              stall,
    output logic              accessFault,
    output logic              registerWriteOut,
    output logic              memoryToRegisterOut,
    output logic [31:0]       ALUresultOut,
    output logic [31:0]       readDataOut,
    output logic [4:0]        writeRegisterOut
);

    localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic              dmemReq_q, dmemWe_q, fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, hold_q;
    logic [3:0]        wstrb_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic [WW-1:0]     wait_q;

    logic        access, isWrite, badF3, misalign, fault;
    logic [31:0] wdata_d, rfmt_d, wordAddr;
    logic [3:0]  wstrb_d;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Request decode, store lane steering and fault detection from the current inputs
    always_comb begin
        access   = memRead | memWrite;
        isWrite  = memWrite & ~memRead;
        badF3    = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
        misalign = ((funct3[1:0] == 2'b01) && ALUresult[0]) ||
                   ((funct3 == 3'd2) && (ALUresult[1:0] != 2'b00));
        fault    = access & (badF3 | misalign);
        wordAddr = {ALUresult[31:2], 2'b00};
        wdata_d  = writeData;
        wstrb_d  = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_d = {4{writeData[7:0]}};
                wstrb_d = 4'b0001 << ALUresult[1:0];
            end
            2'b01: begin
                wdata_d = {2{writeData[15:0]}};
                wstrb_d = ALUresult[1] ? 4'b1100 : 4'b0011;
            end
            default: wstrb_d = 4'b1111;
        endcase
        if (!isWrite) wstrb_d = '0;
    end

    // Load formatting uses the latched size and byte offset, not the live inputs
    always_comb begin
        byteSel = dmemRdata[{lo_q, 3'b000} +: 8];
        halfSel = lo_q[1] ? dmemRdata[31:16] : dmemRdata[15:0];
        case (f3_q)
            3'd0:    rfmt_d = {{24{byteSel[7]}}, byteSel};
            3'd1:    rfmt_d = {{16{halfSel[15]}}, halfSel};
            3'd4:    rfmt_d = {24'd0, byteSel};
            3'd5:    rfmt_d = {16'd0, halfSel};
            default: rfmt_d = dmemRdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            dmemReq_q <= 1'b0;
            dmemWe_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            f3_q      <= '0;
            lo_q      <= '0;
            wait_q    <= '0;
            hold_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access && !fault) begin
                        addr_q    <= ADDR_W'(wordAddr);
                        dmemWe_q  <= isWrite;
                        wdata_q   <= wdata_d;
                        wstrb_q   <= wstrb_d;
                        f3_q      <= funct3;
                        lo_q      <= ALUresult[1:0];
                        wait_q    <= '0;
                        hold_q    <= '0;
                        fault_q   <= 1'b0;
                        dmemReq_q <= 1'b1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmemAck) begin
                        hold_q    <= dmemWe_q ? '0 : rfmt_d;
                        dmemReq_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (wait_q == WAIT_LAST) begin
                        fault_q   <= 1'b1;
                        hold_q    <= '0;
                        dmemReq_q <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmemReq   = dmemReq_q;
    assign dmemWe    = dmemWe_q;
    assign dmemAddr  = addr_q;
    assign dmemWdata = wdata_q;
    assign dmemWstrb = wstrb_q;

    // The instruction holds in EX/MEM from IDLE through DONE, so faults and data are reported in DONE
    always_comb begin
        stall       = ((state_q == IDLE) && access && !fault) || (state_q == BUSY);
        accessFault = ((state_q == IDLE) && fault) || ((state_q == DONE) && fault_q);
        readDataOut = (state_q == DONE) ? hold_q : '0;
        registerWriteOut    = registerWrite & ~accessFault;
        memoryToRegisterOut = memoryToRegister;
        ALUresultOut        = ALUresult;
        writeRegisterOut    = writeRegister;
    end

endmodule

// File: tb/tb_mem_stage_rv.sv
// Randomised scoreboard bench for mem_stage_rv: a reference model predicts each
// instruction's retire values and memory transaction; monitor processes compare.
module tb_mem_stage_rv;

    localparam int unsigned MAXW = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        memRead, memWrite, registerWrite, memoryToRegister;
    logic [2:0]  funct3;
    logic [31:0] ALUresult, writeData;
    logic [4:0]  writeRegister;
    logic        dmemReq, dmemWe, dmemAck;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemWstrb;
    logic        stall, accessFault, registerWriteOut, memoryToRegisterOut;
    logic [31:0] ALUresultOut, readDataOut;
    logic [4:0]  writeRegisterOut;
    logic        respAck = 1'b0, forceAck = 1'b0;

    assign dmemAck = respAck | forceAck;
    always #5 clock = ~clock;

    mem_stage_rv #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .ALUresult(ALUresult), .writeData(writeData),
        .registerWrite(registerWrite), .memoryToRegister(memoryToRegister),
        .writeRegister(writeRegister), .dmemReq(dmemReq), .dmemWe(dmemWe),
        .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemWstrb(dmemWstrb),
        .dmemRdata(dmemRdata), .dmemAck(dmemAck), .stall(stall),
        .accessFault(accessFault), .registerWriteOut(registerWriteOut),
        .memoryToRegisterOut(memoryToRegisterOut), .ALUresultOut(ALUresultOut),
        .readDataOut(readDataOut), .writeRegisterOut(writeRegisterOut)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        fault;
        int unsigned stalls;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int unsigned delay;
    } mem_t;

    exp_t        sb_q[$];
    mem_t        mem_q[$];
    int unsigned n_cmp = 0, n_bad = 0;
    logic        instr_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ldfmt(input int unsigned f3, input int unsigned off,
                                          input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (off * 8)) & 32'hFF;
        h = (w >> ((off / 2) * 16)) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? b - 32'd256 : b;
            1:       return (h >= 32768) ? h - 32'd65536 : h;
            4:       return b;
            5:       return h;
            default: return w;
        endcase
    endfunction

    task automatic set_nop();
        memRead = 0; memWrite = 0; funct3 = 0; ALUresult = 0; writeData = 0;
        registerWrite = 0; memoryToRegister = 0; writeRegister = 0;
    endtask

    // Predict the outcome of one instruction, drive it, and hold it until it retires
    task automatic issue(input logic rd, input logic wr, input int unsigned f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic regW, input logic m2r, input logic [4:0] rdReg,
                         input logic [31:0] rdata, input int unsigned delay);
        exp_t e;
        mem_t m;
        logic acc, flt, done;
        int unsigned off, size;
        acc  = rd | wr;
        off  = addr % 4;
        size = f3 % 4;
        flt  = 0;
        if (acc) begin
            if (f3 == 3 || f3 == 6 || f3 == 7) flt = 1;
            if ((f3 == 1 || f3 == 5) && (off % 2) != 0) flt = 1;
            if (f3 == 2 && off != 0) flt = 1;
        end
        e.alu = addr; e.rd = rdReg; e.m2r = m2r; e.rdata = 0;
        e.fault = flt; e.rw = regW && !flt; e.stalls = 0;
        if (acc && !flt) begin
            m.addr  = addr - off;
            m.we    = !rd;
            m.rdata = rdata;
            m.delay = delay;
            if (size == 0) begin
                m.wdata = (wd & 32'hFF) * 32'h0101_0101;
                m.wstrb = 4'(1 << off);
            end else if (size == 1) begin
                m.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
                m.wstrb = 4'(3 << off);
            end else begin
                m.wdata = wd;
                m.wstrb = 4'hF;
            end
            if (rd) m.wstrb = 0;
            if (delay >= MAXW) begin
                e.fault = 1; e.rw = 0; e.stalls = 1 + MAXW;
            end else begin
                e.stalls = 2 + delay;
                if (rd) e.rdata = ldfmt(f3, off, rdata);
            end
            mem_q.push_back(m);
        end
        sb_q.push_back(e);
        memRead = rd; memWrite = wr; funct3 = 3'(f3); ALUresult = addr; writeData = wd;
        registerWrite = regW; memoryToRegister = m2r; writeRegister = rdReg;
        instr_valid = 1;
        done = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (!stall) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("retire_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        instr_valid = 0;
        set_nop();
    endtask

    // Retire monitor: one scoreboard entry per stall-free cycle of a valid instruction
    int unsigned stall_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (instr_valid && !reset) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("stall_cycles", stall_cnt, e.stalls);
                        chk("accessFault", 32'(accessFault), 32'(e.fault));
                        chk("registerWriteOut", 32'(registerWriteOut), 32'(e.rw));
                        chk("memoryToRegisterOut", 32'(memoryToRegisterOut), 32'(e.m2r));
                        chk("ALUresultOut", ALUresultOut, e.alu);
                        chk("writeRegisterOut", 32'(writeRegisterOut), 32'(e.rd));
                        chk("readDataOut", readDataOut, e.rdata);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Memory responder: checks every request cycle against the predicted transaction
    initial begin
        mem_t cur;
        logic active;
        int unsigned cnt;
        active = 0;
        cnt = 0;
        cur.addr = 0; cur.we = 0; cur.wdata = 0; cur.wstrb = 0; cur.rdata = 0; cur.delay = 0;
        dmemRdata = 0;
        forever begin
            @(negedge clock);
            respAck = 0;
            dmemRdata = $urandom;
            if (dmemReq) begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    if (mem_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                        cur.addr = dmemAddr; cur.we = dmemWe; cur.wdata = dmemWdata;
                        cur.wstrb = dmemWstrb; cur.rdata = 0; cur.delay = 0;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                chk("dmemAddr", dmemAddr, cur.addr);
                chk("dmemWe", 32'(dmemWe), 32'(cur.we));
                chk("dmemWstrb", 32'(dmemWstrb), 32'(cur.wstrb));
                if (cur.we) chk("dmemWdata", dmemWdata, cur.wdata);
                if (cnt == cur.delay) begin
                    respAck = 1;
                    dmemRdata = cur.rdata;
                end
                cnt++;
            end else begin
                active = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int unsigned pick, f3;
        logic [31:0] a;
        set_nop();
        reset = 1;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("reset_dmemReq", 32'(dmemReq), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_accessFault", 32'(accessFault), 32'd0);
        chk("reset_readDataOut", readDataOut, 32'd0);
        @(posedge clock);
        #1;

        issue(0, 0, 0, 32'h1234, 32'h0, 1, 0, 5'd5, 32'h0, 0);
        issue(1, 0, 0, 32'h103, 32'h0, 1, 1, 5'd7, 32'h80FF_7F01, 0);
        issue(1, 0, 4, 32'h103, 32'h0, 1, 1, 5'd7, 32'h80FF_7F01, 0);
        issue(0, 1, 1, 32'h22, 32'hAAAA_BEEF, 0, 0, 5'd0, 32'h0, 1);
        issue(1, 0, 2, 32'h42, 32'h0, 1, 1, 5'd9, 32'h0, 0);
        issue(1, 0, 2, 32'h40, 32'h0, 1, 1, 5'd9, 32'h1357_9BDF, 3);
        issue(1, 0, 1, 32'h46, 32'h0, 1, 1, 5'd10, 32'h8001_1234, MAXW - 1);
        issue(1, 0, 2, 32'h48, 32'h0, 1, 1, 5'd11, 32'hDEAD_BEEF, MAXW);
        issue(1, 1, 5, 32'h4A, 32'h5555, 1, 1, 5'd12, 32'hF00D_CAFE, 2);
        issue(0, 1, 3, 32'h50, 32'h1, 1, 0, 5'd13, 32'h0, 0);

        // Reset while BUSY, then a stray ack in IDLE
        begin
            mem_t m;
            m.addr = 32'h80; m.we = 0; m.wdata = 0; m.wstrb = 0; m.rdata = 0; m.delay = 1000;
            mem_q.push_back(m);
        end
        memRead = 1; funct3 = 3'd2; ALUresult = 32'h80; registerWrite = 1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (dmemReq) begin
                seen = 1;
                break;
            end
        end
        chk("busy_reached", 32'(seen), 32'd1);
        reset = 1;
        @(posedge clock);
        #1 set_nop();
        @(negedge clock);
        chk("rst_busy_dmemReq", 32'(dmemReq), 32'd0);
        chk("rst_busy_stall", 32'(stall), 32'd0);
        reset = 0;
        @(negedge clock);
        forceAck = 1;
        @(negedge clock);
        forceAck = 0;
        chk("late_ack_dmemReq", 32'(dmemReq), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        chk("late_ack_readData", readDataOut, 32'd0);
        chk("late_ack_fault", 32'(accessFault), 32'd0);
        @(posedge clock);
        #1;
        issue(1, 0, 5, 32'h92, 32'h0, 1, 1, 5'd14, 32'hBEEF_0123, 0);

        for (int i = 0; i < 80; i++) begin
            pick = $urandom % 10;
            if (pick < 8) begin
                case ($urandom % 5)
                    0: f3 = 0;
                    1: f3 = 1;
                    2: f3 = 2;
                    3: f3 = 4;
                    default: f3 = 5;
                endcase
            end else begin
                case ($urandom % 3)
                    0: f3 = 3;
                    1: f3 = 6;
                    default: f3 = 7;
                endcase
            end
            a = $urandom;
            if (($urandom % 2) == 0) a[1:0] = 2'b00;
            pick = $urandom % 12;
            issue(1'($urandom % 2), 1'(($urandom % 3) != 0), f3, a, $urandom,
                  1'($urandom % 2), 1'($urandom % 2), 5'($urandom % 32), $urandom,
                  (pick == 11) ? MAXW : ((pick == 10) ? MAXW - 1 : pick % 4));
        end

        repeat (3) @(posedge clock);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("mem_drained", 32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
